alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
- Bit-serial ALU sequencer. Accepts a WIDTH-bit operation, then drives a single alu_top 1-bit slice LSB-first, one bit per clock.
- Feeds each bit's cout back as the next bit's cin and assembles result, zero, cout and overflow.
- Used where area matters more than latency; it is the control/driver end of the 1-bit slice interface, the counterpart to the 32-slice ripple ALU.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
CNT_W, 6, bit-index counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; accepted only in IDLE
src1  input  WIDTH  operand A, captured on accept
src2  input  WIDTH  operand B, captured on accept
ALU_control  input  4  {A_invert, B_invert, operation[1:0]}, captured on accept
bonus_control  input  3  compare code driven to slice comp, captured on accept
busy  output  1  high from accept until done
done  output  1  one-cycle pulse when outputs are valid
result  output  WIDTH  final result, held until next accept
zero  output  1  result == 0, held
cout  output  1  carry out of MSB, held
overflow  output  1  signed overflow of MSB, held

Behaviour:
- Clock/reset: one clock, clk; rst asynchronous active-high. In reset: state=IDLE, busy=0, done=0, result=0, zero=0, cout=0, overflow=0, bit counter=0, internal carry=0.
- ALU_control encodings: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0111 COMPARE.
  - Any other code is executed literally through the slice; no error flag.
- Bonus_control (COMPARE only): 000 lt, 001 gt, 010 le, 011 ge, 100 eq, 101 ne.
  - 110/111 yield result 0.
- FSM states:
  - IDLE: start=1 at edge E captures operands and controls, clears counter, sets carry=B_invert, goes to RUN, busy=1. start=0 stays in IDLE.
  - RUN: at each edge, slice bit i=counter is driven with src1[i], src2[i], carry, A_invert, B_invert, operation, comp.
    - Latch result[i] = slice result (ops 00/01/10).
    - Accumulate sum-nonzero flag from slice set.
    - carry <= slice cout.
    - counter++.
    - At i=WIDTH-1, also latch msb_set, cout, and overflow = carry_in_msb ^ cout_msb. Then go to FIN.
  - FIN (edge E+WIDTH+1):
    - Op 11: result = {0..., cmp}, where cmp is computed from less=msb_set and equal=!sum-nonzero.
    - zero = (result == 0).
    - done=1 for this cycle only; busy=0; return to IDLE.
- Latency: done is high in the cycle following edge E+WIDTH+1, i.e. WIDTH+1 cycles after accept.
- Back-to-back: start in the cycle done is high is accepted in the following IDLE cycle. No overlap with a running operation.
- Signal validity:
  - overflow and cout are meaningful for ADD/SUB/COMPARE. For AND/OR/NOR they are 0.
  - result, zero, cout and overflow change only at FIN and hold otherwise.
- Boundaries:
  - start while busy is ignored; operands are not re-captured.
  - rst mid-RUN aborts immediately to the reset values; no done pulse.
  - Counter never exceeds WIDTH-1; no wrap.

Optional Feature:
SLT_OVERFLOW_FIX_EN
- Defined: compare uses less = msb_set ^ overflow, giving a correct signed compare under overflow.
- Undefined: less = msb_set raw, identical to the ripple ALU.

Test Plan:
- ADD: src1=0x00000005, src2=0x00000003, ctrl 0010, start at edge E -> done in the cycle after edge E+33, result=0x00000008, zero=0, cout=0, overflow=0.
- SUB: 0x7FFFFFFF - 0xFFFFFFFF (ctrl 0110) -> result=0x80000000, overflow=1. Then 5-5 -> result=0, zero=1, cout=1.
- NOR: 0x0F0F0000, 0x00FF0000, ctrl 1100 -> result=0xF000FFFF, cout=0, overflow=0. AND of same operands -> 0x000F0000.
- COMPARE ctrl 0111:
  - eq(5,5) -> result=1, zero=0.
  - ge(3,7) -> result=0, zero=1.
  - lt(0x80000000, 0x00000001) -> 1 with SLT_OVERFLOW_FIX_EN, 0 without.
- Reset/ignore: assert rst at RUN bit 10 -> next cycle busy=0, result=0, no done. start pulse while busy -> ignored; first operation's result is unchanged.

Source files
------------

// File: rtl/alu_serial_ctrl_if.sv
// alu_serial_ctrl_if: operation request and result bus between a requester and the bit-serial ALU sequencer.
interface alu_serial_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       ALU_control;
  logic [2:0]       bonus_control;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;
  modport master (output start, src1, src2, ALU_control, bonus_control,
                  input busy, done, result, zero, cout, overflow);
  modport slave  (input start, src1, src2, ALU_control, bonus_control,
                  output busy, done, result, zero, cout, overflow);
endinterface

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer driving one 1-bit slice LSB-first, one bit per clock.
// Optional SLT_OVERFLOW_FIX_EN: compare uses msb_set ^ overflow as "less" for a signed-safe compare.
module alu_serial_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  alu_serial_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_q, b_q, res_sh, fin_res;
  logic [3:0]       ctrl;
  logic [2:0]       comp;
  logic [CNT_W-1:0] cnt;
  logic carry, nz, msb_set, cout_q, ovf_q, done_q;
  logic ai, bi, s, co, r, last, less, equal, cmp;
  // Operands shift right each RUN cycle so the active bit always sits at position 0.
  always_comb begin
    ai = a_q[0] ^ ctrl[3];
    bi = b_q[0] ^ ctrl[2];
    s = ai ^ bi ^ carry;
    co = (ai & bi) | (ai & carry) | (bi & carry);
    r = ctrl[1:0] == 2'b00 ? ai & bi :
        ctrl[1:0] == 2'b01 ? ai | bi :
        ctrl[1:0] == 2'b10 ? s : 1'b0;
    last = cnt == CNT_W'(WIDTH - 1);
`ifdef SLT_OVERFLOW_FIX_EN
    less = msb_set ^ ovf_q;
`else
    less = msb_set;
`endif
    equal = !nz;
    cmp = comp == 3'd0 ? less :
          comp == 3'd1 ? !less && !equal :
          comp == 3'd2 ? less || equal :
          comp == 3'd3 ? !less :
          comp == 3'd4 ? equal :
          comp == 3'd5 ? !equal : 1'b0;
    fin_res = ctrl[1:0] == 2'b11 ? {{(WIDTH-1){1'b0}}, cmp} : res_sh;
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.start ? RUN : IDLE) :
              state == RUN  ? (last ? FIN : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      res_sh <= '0;
      ctrl <= '0;
      comp <= '0;
      cnt <= '0;
      carry <= 1'b0;
      nz <= 1'b0;
      msb_set <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      bus.result <= '0;
      bus.zero <= 1'b0;
      bus.cout <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE && bus.start) begin
        a_q <= bus.src1;
        b_q <= bus.src2;
        ctrl <= bus.ALU_control;
        comp <= bus.bonus_control;
        cnt <= '0;
        carry <= bus.ALU_control[2];
        nz <= 1'b0;
      end
      if (state == RUN) begin
        a_q <= a_q >> 1;
        b_q <= b_q >> 1;
        res_sh <= {r, res_sh[WIDTH-1:1]};
        nz <= nz | s;
        carry <= co;
        if (!last) cnt <= cnt + 1'b1;
        if (last) begin
          msb_set <= s;
          cout_q <= co;
          ovf_q <= carry ^ co;
        end
      end
      // Logic ops have no meaningful carry chain, so their cout/overflow read as 0.
      if (state == FIN) begin
        bus.result <= fin_res;
        bus.zero <= fin_res == '0;
        bus.cout <= ctrl[1] & cout_q;
        bus.overflow <= ctrl[1] & ovf_q;
        done_q <= 1'b1;
      end
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: scoreboard bench for alu_serial_ctrl with an arithmetic reference model.
module tb_alu_serial_ctrl;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] res;
    logic z, c, v;
    int acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t q[$];
  exp_t last_e;
  alu_serial_ctrl_if #(.WIDTH(W)) bus();
  alu_serial_ctrl #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(string n, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] c, logic [2:0] k);
    exp_t e;
    logic [W-1:0] x, y;
    logic [W:0] s;
    logic ovf, less, eq, cmp;
    x = c[3] ? ~a : a;
    y = c[2] ? ~b : b;
    s = {1'b0, x} + {1'b0, y} + (W+1)'(c[2]);
    ovf = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    less = s[W-1];
`ifdef SLT_OVERFLOW_FIX_EN
    less = less ^ ovf;
`endif
    eq = s[W-1:0] == '0;
    case (k)
      3'd0: cmp = less;
      3'd1: cmp = !less && !eq;
      3'd2: cmp = less || eq;
      3'd3: cmp = !less;
      3'd4: cmp = eq;
      3'd5: cmp = !eq;
      default: cmp = 1'b0;
    endcase
    case (c[1:0])
      2'b00: e.res = x & y;
      2'b01: e.res = x | y;
      2'b10: e.res = s[W-1:0];
      default: e.res = W'(cmp);
    endcase
    e.z = e.res == '0;
    e.c = c[1] & s[W];
    e.v = c[1] & ovf;
    e.acc = 0;
    return e;
  endfunction
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      total++;
      bad++;
      $display("FAIL idle_wait: busy got 1 want 0 after %0d cycles", n);
    end
  endtask
  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] c, logic [2:0] k, bit push);
    exp_t e;
    wait_idle();
    bus.src1 = a;
    bus.src2 = b;
    bus.ALU_control = c;
    bus.bonus_control = k;
    bus.start = 1'b1;
    if (push) begin
      e = model(a, b, c, k);
      e.acc = cyc + 1;
      q.push_back(e);
      last_e = e;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_accept", W'(bus.busy), W'(1));
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want 0 at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("result", bus.result, e.res);
        chk("zero", W'(bus.zero), W'(e.z));
        chk("cout", W'(bus.cout), W'(e.c));
        chk("overflow", W'(bus.overflow), W'(e.v));
        chk("latency", W'(cyc - e.acc), W'(W + 1));
        chk("busy_at_done", W'(bus.busy), W'(0));
      end
    end
  end
  initial begin
    int n;
    logic [3:0] ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};
    logic [W-1:0] a, b;
    bus.start = 1'b0;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.ALU_control = '0;
    bus.bonus_control = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_result", bus.result, '0);
    chk("rst_zero", W'(bus.zero), W'(0));
    chk("rst_cout", W'(bus.cout), W'(0));
    chk("rst_overflow", W'(bus.overflow), W'(0));
    rst = 1'b0;
    @(negedge clk);
    issue(32'h0000_0005, 32'h0000_0003, 4'b0010, 3'd0, 1);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b0110, 3'd0, 1);
    issue(32'h0000_0005, 32'h0000_0005, 4'b0110, 3'd0, 1);
    issue(32'h0F0F_0000, 32'h00FF_0000, 4'b1100, 3'd0, 1);
    issue(32'h0F0F_0000, 32'h00FF_0000, 4'b0000, 3'd0, 1);
    issue(32'h0000_0005, 32'h0000_0005, 4'b0111, 3'd4, 1);
    issue(32'h0000_0003, 32'h0000_0007, 4'b0111, 3'd3, 1);
    issue(32'h8000_0000, 32'h0000_0001, 4'b0111, 3'd0, 1);
    issue(32'h0000_1234, 32'h0000_1111, 4'b0010, 3'd0, 1);
    repeat (5) @(negedge clk);
    bus.src1 = 32'hDEAD_BEEF;
    bus.src2 = 32'h1357_9BDF;
    bus.ALU_control = 4'b0001;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_result", bus.result, last_e.res);
    chk("hold_zero", W'(bus.zero), W'(last_e.z));
    issue(32'hAAAA_AAAA, 32'h5555_5555, 4'b0001, 3'd0, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", W'(bus.busy), W'(0));
    chk("abort_result", bus.result, '0);
    chk("abort_done", W'(bus.done), W'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_restart", W'(bus.busy), W'(0));
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom_range(0, 3) == 0 ? a : $urandom;
      issue(a, b, ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1);
    end
    wait_idle();
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
